// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the MEM-stage LSU (master) and the data memory (slave).
// Valid/ready request channel plus a valid-only read-response channel.
interface mem_stage_lsu_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STRB_W = XLEN / 8
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [XLEN-1:0]   dmem_req_addr;
  logic [XLEN-1:0]   dmem_req_wdata;
  logic [STRB_W-1:0] dmem_req_strb;
  logic              dmem_rsp_valid;
  logic [XLEN-1:0]   dmem_rsp_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_req_we,
    output dmem_req_addr,
    output dmem_req_wdata,
    output dmem_req_strb,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_req_we,
    input  dmem_req_addr,
    input  dmem_req_wdata,
    input  dmem_req_strb,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rsp_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV64I MEM-stage load/store unit: issues one data-memory transaction per access,
// formats load data into ld_data_M and stalls the pipeline while the access is in flight.
module mem_stage_lsu #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STRB_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid_M,
  input  logic            is_load_M,
  input  logic            is_store_M,
  input  logic [2:0]      funct3_M,
  input  logic [XLEN-1:0] alu_out_M,
  input  logic [XLEN-1:0] rs2_data_M,
  mem_stage_lsu_if.master dmem,
  output logic [XLEN-1:0] ld_data_M,
  output logic            lsu_stall,
  output logic            misalign_M
);
  localparam int unsigned OFF_W = $clog2(STRB_W);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            r_state;
  logic              r_req_valid;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [STRB_W-1:0] r_strb;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;
  logic [XLEN-1:0]   r_ld_data;

  logic              w_access;
  logic              w_misaligned;
  logic              w_illegal;
  logic              w_go;
  logic [OFF_W-1:0]  w_off;
  logic [STRB_W-1:0] w_mask;
  logic [XLEN-1:0]   w_rsh;
  logic [XLEN-1:0]   w_ld_fmt;

  assign w_off    = alu_out_M[OFF_W-1:0];
  assign w_access = op_valid_M & (is_load_M | is_store_M);

  always_comb begin
    w_mask       = '0;
    w_misaligned = 1'b0;
    unique case (funct3_M[1:0])
      2'd0: w_mask = STRB_W'(1);
      2'd1: begin
        w_mask       = STRB_W'(3);
        w_misaligned = (w_off & OFF_W'(1)) != '0;
      end
      2'd2: begin
        w_mask       = STRB_W'(15);
        w_misaligned = (w_off & OFF_W'(3)) != '0;
      end
      default: begin
        w_mask       = '1;
        w_misaligned = w_off != '0;
      end
    endcase
  end

  // Loads take priority, so a load/store overlap is judged by the load encoding.
  assign w_illegal  = is_load_M ? (funct3_M == 3'b111) : funct3_M[2];
  assign w_go       = w_access & ~w_misaligned & ~w_illegal;
  assign misalign_M = w_access & w_misaligned;

  assign w_rsh = dmem.dmem_rsp_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld_fmt = w_rsh;
    case (r_funct3)
      3'b000:  w_ld_fmt = {{(XLEN-8){w_rsh[7]}}, w_rsh[7:0]};
      3'b001:  w_ld_fmt = {{(XLEN-16){w_rsh[15]}}, w_rsh[15:0]};
      3'b010:  w_ld_fmt = {{(XLEN-32){w_rsh[31]}}, w_rsh[31:0]};
      3'b100:  w_ld_fmt = {{(XLEN-8){1'b0}}, w_rsh[7:0]};
      3'b101:  w_ld_fmt = {{(XLEN-16){1'b0}}, w_rsh[15:0]};
      3'b110:  w_ld_fmt = {{(XLEN-32){1'b0}}, w_rsh[31:0]};
      default: w_ld_fmt = w_rsh;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_ld_data   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_go) begin
            r_state     <= StReq;
            r_req_valid <= 1'b1;
            r_we        <= ~is_load_M;
            r_addr      <= {alu_out_M[XLEN-1:OFF_W], OFF_W'(0)};
            r_wdata     <= rs2_data_M << {w_off, 3'b000};
            r_strb      <= w_mask << w_off;
            r_funct3    <= funct3_M;
            r_off       <= w_off;
          end
        end
        StReq: begin
          if (dmem.dmem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= r_we ? StDone : StWait;
          end
        end
        StWait: begin
          if (dmem.dmem_rsp_valid) begin
            r_ld_data <= w_ld_fmt;
            r_state   <= StDone;
          end
        end
        // The instruction is still visible on the inputs here; never re-issue it.
        StDone: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    lsu_stall = 1'b0;
    unique case (r_state)
      StIdle:        lsu_stall = w_go;
      StReq, StWait: lsu_stall = 1'b1;
      StDone:        lsu_stall = 1'b0;
    endcase
  end

  assign dmem.dmem_req_valid = r_req_valid;
  assign dmem.dmem_req_we    = r_we;
  assign dmem.dmem_req_addr  = r_addr;
  assign dmem.dmem_req_wdata = r_wdata;
  assign dmem.dmem_req_strb  = r_strb;
  assign ld_data_M           = r_ld_data;
endmodule
